// File: rtl/l2_port_arbiter.sv
// Two-port arbiter that shares one L2 line port between the L1 instruction and data caches.
// One transaction in flight at a time; ties alternate, and all L2-side outputs come from registers.
module l2_port_arbiter #(
    parameter int ADDR_W = 26,
    parameter int LINE_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_L1I_L2,
    input  logic [ADDR_W-1:0] addr_L1I_L2,
    output logic              ready_L2_L1I,
    output logic [LINE_W-1:0] read_data_L2_L1I,
    input  logic              read_L1D_L2,
    input  logic              write_L1D_L2,
    input  logic [ADDR_W-1:0] addr_L1D_L2,
    input  logic [LINE_W-1:0] write_data_L1D_L2,
    output logic              ready_L2_L1D,
    output logic [LINE_W-1:0] read_data_L2_L1D,
    output logic              read_L1_L2,
    output logic              write_L1_L2,
    output logic [ADDR_W-1:0] addr_L1_L2,
    output logic [LINE_W-1:0] write_data_L1_L2,
    input  logic              ready_L2_L1,
    input  logic [LINE_W-1:0] read_data_L2_L1
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic                last_grant_reg, last_grant_next;   // 0: I served last, 1: D served last
    logic                rd_reg, rd_next;
    logic                wr_reg, wr_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [LINE_W-1:0]   wdata_reg, wdata_next;
    logic [LINE_W-1:0]   rdata_i_reg, rdata_i_next;
    logic [LINE_W-1:0]   rdata_d_reg, rdata_d_next;
    logic                ready_i_reg, ready_i_next;
    logic                ready_d_reg, ready_d_next;

    // A side whose ready pulse is showing this cycle is still holding its
    // request; mask it so the stale request is not granted a second time.
    logic req_i, req_d, pick_d;
    assign req_i  = read_L1I_L2 && !ready_i_reg;
    assign req_d  = (read_L1D_L2 || write_L1D_L2) && !ready_d_reg;
    assign pick_d = req_d && (!req_i || !last_grant_reg);

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        rd_next         = rd_reg;
        wr_next         = wr_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_i_next    = rdata_i_reg;
        rdata_d_next    = rdata_d_reg;
        ready_i_next    = 1'b0;
        ready_d_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_d) begin
                    state_next      = GRANT_D;
                    last_grant_next = 1'b1;
                    // Writeback takes priority; a concurrent refill follows as its own transaction.
                    wr_next         = write_L1D_L2;
                    rd_next         = !write_L1D_L2;
                    addr_next       = addr_L1D_L2;
                    wdata_next      = write_L1D_L2 ? write_data_L1D_L2 : '0;
                end else if (req_i) begin
                    state_next      = GRANT_I;
                    last_grant_next = 1'b0;
                    rd_next         = 1'b1;
                    wr_next         = 1'b0;
                    addr_next       = addr_L1I_L2;
                    wdata_next      = '0;
                end
            end
            GRANT_I: begin
                if (ready_L2_L1) begin
                    state_next   = IDLE;
                    rdata_i_next = read_data_L2_L1;
                    ready_i_next = 1'b1;
                    rd_next      = 1'b0;
                    wr_next      = 1'b0;
                end
            end
            GRANT_D: begin
                if (ready_L2_L1) begin
                    state_next   = IDLE;
                    rdata_d_next = read_data_L2_L1;
                    ready_d_next = 1'b1;
                    rd_next      = 1'b0;
                    wr_next      = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                rd_next    = 1'b0;
                wr_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b0;
            rd_reg         <= 1'b0;
            wr_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_i_reg    <= '0;
            rdata_d_reg    <= '0;
            ready_i_reg    <= 1'b0;
            ready_d_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            rd_reg         <= rd_next;
            wr_reg         <= wr_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_i_reg    <= rdata_i_next;
            rdata_d_reg    <= rdata_d_next;
            ready_i_reg    <= ready_i_next;
            ready_d_reg    <= ready_d_next;
        end
    end

    assign read_L1_L2       = rd_reg;
    assign write_L1_L2      = wr_reg;
    assign addr_L1_L2       = addr_reg;
    assign write_data_L1_L2 = wdata_reg;
    assign ready_L2_L1I     = ready_i_reg;
    assign read_data_L2_L1I = rdata_i_reg;
    assign ready_L2_L1D     = ready_d_reg;
    assign read_data_L2_L1D = rdata_d_reg;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios plus randomized requesters and L2 responder,
// checked every cycle against a transaction-level reference model.
module tb_l2_port_arbiter;
    localparam int AW = 26;
    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          ri;
    logic [AW-1:0] ai;
    logic          rdd, wd;
    logic [AW-1:0] ad;
    logic [LW-1:0] wdat;
    logic          l2rdy;
    logic [LW-1:0] l2data;
    logic          rdy_i, rdy_d, l2_rd, l2_wr;
    logic [LW-1:0] rdat_i, rdat_d, l2_wdata;
    logic [AW-1:0] l2_addr;

    always #5 clk = ~clk;

    l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .read_L1I_L2(ri), .addr_L1I_L2(ai),
        .ready_L2_L1I(rdy_i), .read_data_L2_L1I(rdat_i),
        .read_L1D_L2(rdd), .write_L1D_L2(wd), .addr_L1D_L2(ad),
        .write_data_L1D_L2(wdat),
        .ready_L2_L1D(rdy_d), .read_data_L2_L1D(rdat_d),
        .read_L1_L2(l2_rd), .write_L1_L2(l2_wr),
        .addr_L1_L2(l2_addr), .write_data_L1_L2(l2_wdata),
        .ready_L2_L1(l2rdy), .read_data_L2_L1(l2data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: who owns the port (0 none, 1 I, 2 D), who was served last,
    // the outstanding L2 command, and the per-side delivered line and pulse.
    int            m_owner, m_last;
    bit            m_rd, m_wr, m_pi, m_pd;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_di, m_dd;
    int            seq[$];

    task automatic model_edge();
        bit want_i, want_d, pi_old, pd_old;
        if (rst) begin
            m_owner = 0; m_last = 1; m_rd = 0; m_wr = 0; m_pi = 0; m_pd = 0;
            m_addr = '0; m_wdata = '0; m_di = '0; m_dd = '0;
            return;
        end
        pi_old = m_pi; pd_old = m_pd;
        m_pi = 0; m_pd = 0;
        if (m_owner == 0) begin
            want_i = ri && !pi_old;
            want_d = (rdd || wd) && !pd_old;
            if (want_i && want_d) begin
                if (m_last == 1) want_i = 0;
                else             want_d = 0;
            end
            if (want_d) begin
                m_owner = 2; m_last = 2; m_wr = wd; m_rd = !wd;
                m_addr = ad; m_wdata = wd ? wdat : '0;
            end else if (want_i) begin
                m_owner = 1; m_last = 1; m_rd = 1; m_wr = 0;
                m_addr = ai; m_wdata = '0;
            end
        end else if (l2rdy) begin
            if (m_owner == 1) begin m_di = l2data; m_pi = 1; end
            else              begin m_dd = l2data; m_pd = 1; end
            m_owner = 0; m_rd = 0; m_wr = 0;
        end
    endtask

    task automatic check_all();
        check("ready_i", LW'(rdy_i), LW'(m_pi));
        check("ready_d", LW'(rdy_d), LW'(m_pd));
        check("l2_read", LW'(l2_rd), LW'(m_rd));
        check("l2_write", LW'(l2_wr), LW'(m_wr));
        check("rdata_i", rdat_i, m_di);
        check("rdata_d", rdat_d, m_dd);
        if (m_rd || m_wr) begin
            check("l2_addr", LW'(l2_addr), LW'(m_addr));
            check("l2_wdata", l2_wdata, m_wdata);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        if (rdy_i) seq.push_back(1);
        if (rdy_d) seq.push_back(2);
    endtask

    task automatic do_reset();
        rst = 1; ri = 0; rdd = 0; wd = 0; l2rdy = 0;
        cycle();
        rst = 0;
    endtask

    int            n, lat;
    bit            drop_i, drop_d;
    logic [LW-1:0] line;

    initial begin
        ai = '0; ad = '0; wdat = '0; l2data = '0;
        do_reset();
        check("reset_l2_read", LW'(l2_rd), '0);
        check("reset_rdata_i", rdat_i, '0);

        // I read alone, L2 answers on the third request cycle
        ri = 1; ai = 26'h0000ABC;
        cycle();
        n = 0;
        for (int k = 0; k < 3; k++) begin
            if (l2_rd && l2_addr == 26'h0000ABC) n++;
            if (k == 2) begin l2rdy = 1; line = rand_line(); l2data = line; end
            cycle();
        end
        check("i_read_req_cycles", LW'(n), LW'(3));
        check("i_read_pulse", LW'(rdy_i), LW'(1));
        check("i_read_line", rdat_i, line);
        ri = 0; l2rdy = 0;
        cycle();
        check("i_read_single_pulse", LW'(rdy_i), LW'(0));

        // simultaneous I and D after reset: D first, then I
        do_reset();
        ri = 1; ai = 26'h1111111; rdd = 1; ad = 26'h2222222;
        cycle();
        check("tie_d_first", LW'(l2_addr), LW'(26'h2222222));
        l2rdy = 1; l2data = rand_line();
        cycle();
        rdd = 0; l2rdy = 0;
        cycle();
        check("tie_i_second", LW'(l2_addr), LW'(26'h1111111));
        l2rdy = 1; l2data = rand_line();
        cycle();
        ri = 0; l2rdy = 0;
        cycle();

        // D read+write held: writeback first, then refill
        do_reset();
        rdd = 1; wd = 1; ad = 26'h0345678; wdat = {64{8'hA5}};
        cycle();
        check("wb_first_write", LW'(l2_wr), LW'(1));
        check("wb_first_data", l2_wdata, {64{8'hA5}});
        l2rdy = 1; l2data = rand_line();
        cycle();
        l2rdy = 0;
        cycle();
        wd = 0;
        cycle();
        check("wb_then_read", LW'(l2_rd), LW'(1));
        check("wb_read_wdata_zero", l2_wdata, '0);
        l2rdy = 1; l2data = rand_line();
        cycle();
        rdd = 0; l2rdy = 0;
        cycle();

        // reset mid-transaction, then a late L2 ready must be ignored
        do_reset();
        ri = 1; ai = 26'h0ABCDEF;
        cycle();
        cycle();
        rst = 1; ri = 0;
        cycle();
        rst = 0;
        check("abort_read_low", LW'(l2_rd), LW'(0));
        l2rdy = 1; l2data = rand_line();
        cycle();
        check("late_ready_no_pulse", LW'(rdy_i), LW'(0));
        l2rdy = 0;
        cycle();
        check("late_ready_no_req", LW'(l2_rd), LW'(0));

        // both sides held continuously: grants alternate D,I,D,I,D,I
        do_reset();
        seq.delete();
        ri = 1; rdd = 1; ai = 26'h0000111; ad = 26'h0000222;
        for (int k = 0; k < 40 && seq.size() < 6; k++) begin
            cycle();
            l2rdy = l2_rd || l2_wr;
            l2data = rand_line();
        end
        check("alt_count", LW'(seq.size() >= 6), LW'(1));
        for (int k = 0; k < 6 && k < seq.size(); k++)
            check($sformatf("alt_grant%0d", k), LW'(seq[k]), LW'((k % 2 == 0) ? 2 : 1));
        ri = 0; rdd = 0; l2rdy = 0;
        cycle();

        // randomized traffic with occasional reset and spurious L2 ready
        do_reset();
        lat = 1; drop_i = 0; drop_d = 0;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            rst = ($urandom_range(0, 79) == 0);
            l2rdy = 0;
            if (l2_rd || l2_wr) begin
                if (lat == 0) begin
                    l2rdy = 1; l2data = rand_line(); lat = $urandom_range(0, 3);
                end else lat--;
            end else if ($urandom_range(0, 15) == 0) begin
                l2rdy = 1; l2data = rand_line();
            end
            if (drop_i) begin ri = 0; drop_i = 0; end
            else if (rdy_i) drop_i = 1;
            else if (!ri) begin
                ai = AW'($urandom);
                if ($urandom_range(0, 2) == 0) ri = 1;
            end
            if (drop_d) begin
                if (wd) wd = 0; else rdd = 0;
                drop_d = 0;
            end else if (rdy_d) drop_d = 1;
            else if (!rdd && !wd) begin
                ad = AW'($urandom);
                wdat = rand_line();
                if ($urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 2))
                        0: rdd = 1;
                        1: wd = 1;
                        default: begin rdd = 1; wd = 1; end
                    endcase
                end
            end else if (!wd) wdat = rand_line();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
